// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter. It shares one DMEM port between the core MEM stage (c_*)
// and a debug/loader master (d_*). The core normally has priority. A debug master that
// has waited long enough wins once, and a debug lock holds the port for burst access.
// Out-of-window or misaligned accesses are granted with an error response, and they
// never reach memory.
module dmem_port_arbiter #(
  parameter logic [31:0] DMEM_BASE  = 32'h0000_1000,
  parameter int unsigned DMEM_WORDS = 1024,
  parameter int unsigned AW         = 10,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [31:0]   c_addr,
  input  logic [3:0]    c_be,
  input  logic [31:0]   c_wd,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [31:0]   c_rdata,
  output logic          c_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [3:0]    d_be,
  input  logic [31:0]   d_wd,
  input  logic          d_lock,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  // The end of the window is computed in 33 bits so that a window ending at 4 GiB does not wrap.
  localparam logic [32:0] LIMIT = {1'b0, DMEM_BASE} + 33'(DMEM_WORDS) * 33'd4;

  typedef enum logic {NORMAL, LOCKED} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt;
  logic          rsp_c, rsp_d, rsp_err, rsp_rd;
  logic [31:0]   sel_addr;
  logic          sel_ok, any_gnt;

  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, DMEM_BASE}) && ({1'b0, a} < LIMIT) && (a[1:0] == 2'b00);
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= NORMAL;
    else        state <= state_nxt;
  end

  // Next-state: lock on a locked debug grant, and release at the edge where d_lock falls
  always_comb begin
    state_nxt = state;
    unique case (state)
      NORMAL: if (d_gnt && d_lock) state_nxt = LOCKED;
      LOCKED: if (!d_lock)         state_nxt = NORMAL;
      default:                     state_nxt = NORMAL;
    endcase
  end

  // Grant selection: starved debug first, then core, then debug. Only debug is granted while locked.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n) begin
      if (state == LOCKED) begin
        d_gnt = d_req;
      end else if (d_req && wait_cnt == WW'(MAX_WAIT)) begin
        d_gnt = 1'b1;
      end else if (c_req) begin
        c_gnt = 1'b1;
      end else begin
        d_gnt = d_req;
      end
    end
  end

  // Debug starvation counter. It saturates at MAX_WAIT and is cleared when debug is served or idle.
  always_ff @(posedge clk) begin
    if (!rst_n)                                          wait_cnt <= '0;
    else if (!d_req || d_gnt)                            wait_cnt <= '0;
    else if (state == NORMAL && wait_cnt != WW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
  end

  // Memory-side mux. All fields are forced to zero unless an in-window access is granted.
  always_comb begin
    any_gnt  = c_gnt | d_gnt;
    sel_addr = d_gnt ? d_addr : c_addr;
    sel_ok   = in_range(sel_addr);
    mem_en   = any_gnt & sel_ok;
    mem_we   = 1'b0;
    mem_be   = '0;
    mem_wd   = '0;
    mem_addr = '0;
    if (mem_en) begin
      mem_we   = d_gnt ? d_we : c_we;
      mem_be   = d_gnt ? d_be : c_be;
      mem_wd   = d_gnt ? d_wd : c_wd;
      mem_addr = AW'((sel_addr - DMEM_BASE) >> 2);
    end
  end

  // Response tracking: the owner, error flag and read flag of last cycle's grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_c   <= 1'b0;
      rsp_d   <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rd  <= 1'b0;
    end else begin
      rsp_c   <= c_gnt;
      rsp_d   <= d_gnt;
      rsp_err <= any_gnt & ~sel_ok;
      rsp_rd  <= mem_en & ~mem_we;
    end
  end

  // Response routing. It is masked during reset so that a pending completion is dropped.
  always_comb begin
    c_rvalid = rst_n & rsp_c;
    d_rvalid = rst_n & rsp_d;
    c_err    = c_rvalid & rsp_err;
    d_err    = d_rvalid & rsp_err;
    c_rdata  = (c_rvalid && rsp_rd) ? mem_rdata : '0;
    d_rdata  = (d_rvalid && rsp_rd) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed testbench for dmem_port_arbiter.
module tb_dmem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_we, d_req, d_we, d_lock;
  logic [31:0] c_addr, c_wd, d_addr, d_wd, mem_rdata;
  logic [3:0]  c_be, d_be;
  logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
  logic [31:0] c_rdata, d_rdata, mem_wd;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;
  int          total = 0;
  int          bad = 0;

  dmem_port_arbiter #(.DMEM_BASE(32'h0000_1000), .DMEM_WORDS(1024), .AW(10), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_be(c_be), .c_wd(c_wd),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wd(d_wd), .d_lock(d_lock),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wd(mem_wd), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Advance to the next cycle. Inputs change 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c_req = 0; c_we = 0; c_addr = '0; c_be = '0; c_wd = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_be = '0; d_wd = '0; d_lock = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle(); c_req = 1; d_req = 1; c_addr = 32'h1000; d_addr = 32'h1004;
    mem_rdata = 32'h5555_AAAA;
    next_cycle(); next_cycle(); #1;
    total++; if (c_gnt !== 1'b0 || d_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt got c=%b d=%b exp 0 0", c_gnt, d_gnt); end
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
    total++; if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0 || c_rdata !== 32'h0 || d_rdata !== 32'h0)
      begin bad++; $display("FAIL reset_rsp got cv=%b dv=%b cr=%h dr=%h exp all 0", c_rvalid, d_rvalid, c_rdata, d_rdata); end
    idle(); rst_n = 1;
    next_cycle();
  endtask

  task automatic test_core_read();
    c_req = 1; c_addr = 32'h1004; c_be = 4'hF; #1;
    total++; if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin bad++; $display("FAIL rd_gnt got c=%b d=%b exp 1 0", c_gnt, d_gnt); end
    total++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd1)
      begin bad++; $display("FAIL rd_mem got en=%b we=%b addr=%0d exp 1 0 1", mem_en, mem_we, mem_addr); end
    next_cycle(); idle(); mem_rdata = 32'hDEAD_BEEF; #1;
    total++; if (c_rvalid !== 1'b1 || c_rdata !== 32'hDEAD_BEEF || c_err !== 1'b0 || d_rvalid !== 1'b0)
      begin bad++; $display("FAIL rd_rsp got v=%b d=%h e=%b dv=%b exp 1 deadbeef 0 0", c_rvalid, c_rdata, c_err, d_rvalid); end
    next_cycle();
  endtask

  task automatic test_starvation();
    logic [5:0] exp_c;
    exp_c = 6'b10_1111; // bit i-1: core owns cycle i
    c_req = 1; c_addr = 32'h1000; d_req = 1; d_addr = 32'h1008;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++; if (c_gnt !== exp_c[i] || d_gnt !== ~exp_c[i])
        begin bad++; $display("FAIL starve_cyc%0d got c=%b d=%b exp c=%b d=%b", i + 1, c_gnt, d_gnt, exp_c[i], ~exp_c[i]); end
      if (i == 5) begin
        total++; if (d_rvalid !== 1'b1 || c_rvalid !== 1'b0)
          begin bad++; $display("FAIL starve_rsp got dv=%b cv=%b exp 1 0", d_rvalid, c_rvalid); end
      end
      next_cycle();
    end
    idle(); next_cycle();
  endtask

  task automatic test_lock();
    c_req = 1; c_addr = 32'h1100; d_req = 1; d_lock = 1; d_we = 1; d_be = 4'b0011;
    d_addr = 32'h1000; d_wd = 32'hA0A0_0000;
    // Build up the wait count until debug takes the port and locks it.
    for (int i = 0; i < 4; i++) next_cycle();
    for (int k = 0; k < 3; k++) begin
      d_addr = 32'h1000 + 32'(4 * k); d_wd = 32'hA0A0_0000 + 32'(k);
      if (k == 2) d_lock = 0;
      #1;
      total++; if (c_gnt !== 1'b0 || d_gnt !== 1'b1) begin bad++; $display("FAIL lock_gnt%0d got c=%b d=%b exp 0 1", k, c_gnt, d_gnt); end
      total++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_addr !== 10'(k) || mem_wd !== 32'hA0A0_0000 + 32'(k))
        begin bad++; $display("FAIL lock_mem%0d got en=%b we=%b be=%b a=%0d wd=%h exp 1 1 0011 %0d %h", k, mem_en, mem_we, mem_be, mem_addr, mem_wd, k, 32'hA0A0_0000 + 32'(k)); end
      next_cycle();
    end
    d_req = 0; #1;
    total++; if (c_gnt !== 1'b1) begin bad++; $display("FAIL unlock_cgnt got=%b exp=1", c_gnt); end
    next_cycle(); idle(); next_cycle();
  endtask

  task automatic test_range();
    logic [31:0] bad_addr [3];
    bad_addr[0] = 32'h0FFC; bad_addr[1] = 32'h2000; bad_addr[2] = 32'h1002;
    mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      // The 0x2000 case uses the debug master, so the debug error path is also checked.
      if (i == 1) begin d_req = 1; d_addr = bad_addr[i]; end
      else begin c_req = 1; c_addr = bad_addr[i]; end
      #1;
      total++; if ((c_gnt | d_gnt) !== 1'b1 || mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 10'd0)
        begin bad++; $display("FAIL oor_req%0d got gnt=%b en=%b we=%b a=%0d exp 1 0 0 0", i, c_gnt | d_gnt, mem_en, mem_we, mem_addr); end
      next_cycle(); idle(); #1;
      if (i == 1) begin
        total++; if (d_rvalid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0 || c_rvalid !== 1'b0)
          begin bad++; $display("FAIL oor_rsp%0d got v=%b e=%b d=%h cv=%b exp 1 1 0 0", i, d_rvalid, d_err, d_rdata, c_rvalid); end
      end else begin
        total++; if (c_rvalid !== 1'b1 || c_err !== 1'b1 || c_rdata !== 32'h0 || d_rvalid !== 1'b0)
          begin bad++; $display("FAIL oor_rsp%0d got v=%b e=%b d=%h dv=%b exp 1 1 0 0", i, c_rvalid, c_err, c_rdata, d_rvalid); end
      end
      next_cycle();
    end
    c_req = 1; c_addr = 32'h1FFC; c_be = 4'hF; #1;
    total++; if (mem_en !== 1'b1 || mem_addr !== 10'd1023) begin bad++; $display("FAIL top_word got en=%b a=%0d exp 1 1023", mem_en, mem_addr); end
    next_cycle(); idle(); mem_rdata = 32'h0BAD_F00D; #1;
    total++; if (c_rvalid !== 1'b1 || c_err !== 1'b0 || c_rdata !== 32'h0BAD_F00D)
      begin bad++; $display("FAIL top_word_rsp got v=%b e=%b d=%h exp 1 0 0badf00d", c_rvalid, c_err, c_rdata); end
    next_cycle();
  endtask

  task automatic test_reset_locked();
    d_req = 1; d_lock = 1; d_addr = 32'h1000; next_cycle();   // grant, enters LOCKED
    #1;
    total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL rl_gnt got=%b exp=1", d_gnt); end
    next_cycle(); rst_n = 0; #1;
    total++; if (d_rvalid !== 1'b0 || d_gnt !== 1'b0) begin bad++; $display("FAIL rl_drop got v=%b g=%b exp 0 0", d_rvalid, d_gnt); end
    next_cycle(); rst_n = 1; c_req = 1; c_addr = 32'h1000; #1;
    total++; if (c_gnt !== 1'b1 || d_gnt !== 1'b0 || d_rvalid !== 1'b0)
      begin bad++; $display("FAIL rl_after got c=%b d=%b dv=%b exp 1 0 0", c_gnt, d_gnt, d_rvalid); end
    next_cycle(); idle(); next_cycle();
  endtask

  task automatic test_core_store();
    c_req = 1; c_we = 1; c_addr = 32'h1010; c_wd = 32'h1234_5678; c_be = 4'hF; #1;
    total++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'd4 || mem_wd !== 32'h1234_5678 || mem_be !== 4'hF)
      begin bad++; $display("FAIL st_mem got en=%b we=%b a=%0d wd=%h be=%b exp 1 1 4 12345678 1111", mem_en, mem_we, mem_addr, mem_wd, mem_be); end
    next_cycle(); idle(); mem_rdata = 32'hAAAA_AAAA; #1;
    total++; if (c_rvalid !== 1'b1 || c_rdata !== 32'h0 || c_err !== 1'b0)
      begin bad++; $display("FAIL st_rsp got v=%b d=%h e=%b exp 1 0 0", c_rvalid, c_rdata, c_err); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    c_req = 1; c_addr = 32'h1000; next_cycle();
    idle(); d_req = 1; d_addr = 32'h1004; mem_rdata = 32'h1111_2222; #1;
    total++; if (d_gnt !== 1'b1 || mem_addr !== 10'd1 || c_rvalid !== 1'b1 || c_rdata !== 32'h1111_2222 || d_rvalid !== 1'b0)
      begin bad++; $display("FAIL b2b_1 got dg=%b a=%0d cv=%b cd=%h dv=%b exp 1 1 1 11112222 0", d_gnt, mem_addr, c_rvalid, c_rdata, d_rvalid); end
    next_cycle(); idle(); mem_rdata = 32'h3333_4444; #1;
    total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h3333_4444 || c_rvalid !== 1'b0 || c_rdata !== 32'h0)
      begin bad++; $display("FAIL b2b_2 got dv=%b dd=%h cv=%b cd=%h exp 1 33334444 0 0", d_rvalid, d_rdata, c_rvalid, c_rdata); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_starvation();
    test_lock();
    test_range();
    test_reset_locked();
    test_core_store();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
